hazard_scoreboard: RTL

- ID-stage producer of the forwarding selects and stall requests that the EX-stage operand muxes consume.
- Tracks in-flight destination registers through EX/MEM/WB.
- Detects load-use and long-latency multiply hazards and stalls IF/ID.
- Registers the 3-bit one-hot forwarding selects into the ID/EX boundary so EX receives them with zero combinational lookup.

---
 rtl/hazard_scoreboard_pkg.sv | 27 ++
 rtl/hazard_scoreboard_mul_tracker.sv | 61 ++++++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard:
// forwarding select encoding and in-flight stage tags.
package hazard_scoreboard_pkg;

  localparam int TAG_AW = 5;

  localparam logic [2:0] FWD_RF    = 3'b001;
  localparam logic [2:0] FWD_EXMEM = 3'b010;
  localparam logic [2:0] FWD_MEMWB = 3'b100;

  typedef struct packed {
    logic              v;
    logic [TAG_AW-1:0] rd;
    logic              load;
  } stage_tag_t;

  // EX/MEM wins over MEM/WB; a WB-only match reads the regfile
  function automatic logic [2:0] fwd_sel(
    input logic ex_hit,
    input logic mem_hit
  );
    if (ex_hit)       return FWD_EXMEM;
    else if (mem_hit) return FWD_MEMWB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_mul_tracker.sv
// Multi-cycle multiply occupancy: countdown, writeback
// strobe and the busy-unit hazard compare.
module mul_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW  = TAG_AW,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_mul_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              rd_a_i,
  input  logic              rd_b_i,
  input  logic              id_reg_write_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_is_mul_i,
  output logic              hazard_o,
  output logic              wr_en_o,
  output logic [REG_AW-1:0] wr_rd_o
);

  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              busy;
  logic              raw, waw;

  always_comb begin
    busy = (cnt_q != 4'd0);
    raw  = (rd_a_i & (id_rs_i == rd_q))
         | (rd_b_i & (id_rt_i == rd_q));
    waw  = id_reg_write_i
         & (id_rd_i != '0)
         & (id_rd_i == rd_q);
    hazard_o = busy & (raw | waw | id_is_mul_i);
    wr_en_o  = (cnt_q == 4'd1) & (rd_q != '0);
    wr_rd_o  = rd_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    if (busy) cnt_d = cnt_q - 4'd1;
    if (issue_mul_i) begin
      cnt_d = 4'(MUL_LAT);
      rd_d  = id_rd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: load-use and multiply stalls,
// registered one-hot forwarding selects for EX.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW  = TAG_AW,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_flush,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  output logic              stall,
  output logic [2:0]        fwdA,
  output logic [2:0]        fwdB,
  output logic              mul_wr_en,
  output logic [REG_AW-1:0] mul_wr_rd
);

  stage_tag_t ex_q, mem_q, wb_q, ex_d;
  logic [2:0] fwd_a_q, fwd_a_d;
  logic [2:0] fwd_b_q, fwd_b_d;

  logic rd_a, rd_b, wr_ok;
  logic load_use, mul_haz, issue;
  logic ex_a, ex_b, mem_a, mem_b;

  mul_tracker #(
    .REG_AW  (REG_AW),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_mul_i    (issue & id_is_mul),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .rd_a_i         (rd_a),
    .rd_b_i         (rd_b),
    .id_reg_write_i (id_reg_write),
    .id_rd_i        (id_rd),
    .id_is_mul_i    (id_is_mul),
    .hazard_o       (mul_haz),
    .wr_en_o        (mul_wr_en),
    .wr_rd_o        (mul_wr_rd)
  );

  always_comb begin
    rd_a  = id_use_rs & (id_rs != '0);
    rd_b  = id_use_rt & (id_rt != '0);
    wr_ok = id_reg_write & (id_rd != '0) & ~id_is_mul;

    ex_a  = ex_q.v  & rd_a & (ex_q.rd  == id_rs);
    ex_b  = ex_q.v  & rd_b & (ex_q.rd  == id_rt);
    mem_a = mem_q.v & rd_a & (mem_q.rd == id_rs);
    mem_b = mem_q.v & rd_b & (mem_q.rd == id_rt);

    load_use = ex_q.load & (ex_a | ex_b);
    stall    = id_valid & ~id_flush & (load_use | mul_haz);
    issue    = id_valid & ~id_flush & ~stall;
  end

  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (issue) begin
      ex_d.v    = wr_ok;
      ex_d.rd   = id_rd;
      ex_d.load = id_is_load;
      fwd_a_d   = fwd_sel(ex_a, mem_a);
      fwd_b_d   = fwd_sel(ex_b, mem_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwdA = fwd_a_q;
  assign fwdB = fwd_b_q;

endmodule
